run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 151 +++++++++++++++
 tb/tb_run_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run sequencer for a small CPU: snapshots operands, pulses CPU reset, streams
// operands into the CPU, then lets it run until a halt address or a cycle budget.
module run_ctrl #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16,
    parameter int RST_CYC = 2,
    localparam int IDX_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_OPS*DATA_W-1:0] op_data,
    input  logic [ADDR_W-1:0]         halt_addr,
    input  logic [CNT_W-1:0]          max_cycles,
    input  logic [ADDR_W-1:0]         pc,
    output logic                      cpu_rst,
    output logic                      cpu_en,
    output logic                      ld_valid,
    output logic [IDX_W-1:0]          ld_idx,
    output logic [DATA_W-1:0]         ld_data,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [CNT_W-1:0]          cycles
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        LOAD,
        RUN,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  ops_q [NUM_OPS];
    logic [DATA_W-1:0]  ops_d [NUM_OPS];
    logic [DATA_W-1:0]  op_word [NUM_OPS];
    logic [ADDR_W-1:0]  halt_q, halt_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [RC_W-1:0]    rc_q, rc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               timeout_q, timeout_d;

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_unpack
        assign op_word[gi] = op_data[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d   = state_q;
        ops_d     = ops_q;
        halt_d    = halt_q;
        max_d     = max_q;
        rc_d      = rc_q;
        idx_d     = idx_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CRST;
                    ops_d     = op_word;
                    halt_d    = halt_addr;
                    max_d     = max_cycles;
                    rc_d      = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            CRST: begin
                if (rc_q == RC_LAST) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            LOAD: begin
                if (idx_q == IDX_LAST) begin
                    state_d  = RUN;
                    cycles_d = CNT_ONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RUN: begin
                // Halt is checked first so a coincident budget hit is not a timeout.
                if (pc == halt_q) begin
                    state_d   = FIN;
                    timeout_d = 1'b0;
                end else if ((max_q != '0) && (cycles_q == max_q)) begin
                    state_d   = FIN;
                    timeout_d = 1'b1;
                end else if (cycles_q != CNT_SAT) begin
                    cycles_d = cycles_q + CNT_ONE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            halt_q    <= '0;
            max_q     <= '0;
            rc_q      <= '0;
            idx_q     <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) begin
                ops_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ops_q     <= ops_d;
            halt_q    <= halt_d;
            max_q     <= max_d;
            rc_q      <= rc_d;
            idx_q     <= idx_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    assign cpu_rst  = (state_q == CRST);
    assign cpu_en   = (state_q == RUN);
    assign ld_valid = (state_q == LOAD);
    assign ld_idx   = ld_valid ? idx_q : '0;
    assign ld_data  = ld_valid ? ops_q[idx_q] : '0;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: hand-computed run sequences, resets mid-run,
// FIN/IDLE start handling and counter saturation with an 8-bit counter.
module tb_run_ctrl;

    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 2;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 8;
    localparam int RST_CYC = 2;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic [NUM_OPS*DATA_W-1:0] op_data;
    logic [ADDR_W-1:0]         halt_addr;
    logic [CNT_W-1:0]          max_cycles;
    logic [ADDR_W-1:0]         pc;
    logic                      cpu_rst;
    logic                      cpu_en;
    logic                      ld_valid;
    logic [0:0]                ld_idx;
    logic [DATA_W-1:0]         ld_data;
    logic                      busy;
    logic                      done;
    logic                      timeout;
    logic [CNT_W-1:0]          cycles;

    int checks_cnt = 0;
    int errors_cnt = 0;

    run_ctrl #(
        .DATA_W  (DATA_W),
        .NUM_OPS (NUM_OPS),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .RST_CYC (RST_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_data    (op_data),
        .halt_addr  (halt_addr),
        .max_cycles (max_cycles),
        .pc         (pc),
        .cpu_rst    (cpu_rst),
        .cpu_en     (cpu_en),
        .ld_valid   (ld_valid),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".cpu_rst"},  cpu_rst,  0);
        check_eq({tag, ".cpu_en"},   cpu_en,   0);
        check_eq({tag, ".ld_valid"}, ld_valid, 0);
        check_eq({tag, ".ld_idx"},   ld_idx,   0);
        check_eq({tag, ".ld_data"},  ld_data,  0);
        check_eq({tag, ".busy"},     busy,     0);
        check_eq({tag, ".done"},     done,     0);
        check_eq({tag, ".timeout"},  timeout,  0);
        check_eq({tag, ".cycles"},   cycles,   0);
    endtask

    // Full run from an IDLE cycle; inputs are scrambled after acceptance and
    // start is held high while busy, neither of which may disturb the run.
    task automatic do_run(input string name, input logic [31:0] o0, input logic [31:0] o1,
                          input logic [7:0] halt, input logic [7:0] maxc,
                          input int match_k, input int exp_cyc, input logic exp_to,
                          input logic chain);
        logic [7:0] miss;
        miss       = halt + 8'd1;
        op_data    = {o1, o0};
        halt_addr  = halt;
        max_cycles = maxc;
        pc         = miss;
        start      = 1'b1;
        for (int c = 0; c < RST_CYC; c++) begin
            tick();
            op_data    = ~{o1, o0};
            halt_addr  = miss;
            max_cycles = 8'd1;
            check_eq({name, ".crst.cpu_rst"}, cpu_rst, 1);
            check_eq({name, ".crst.cpu_en"},  cpu_en,  0);
            check_eq({name, ".crst.busy"},    busy,    1);
            check_eq({name, ".crst.cycles"},  cycles,  0);
            check_eq({name, ".crst.timeout"}, timeout, 0);
        end
        for (int i = 0; i < NUM_OPS; i++) begin
            tick();
            check_eq({name, ".load.valid"},   ld_valid, 1);
            check_eq({name, ".load.idx"},     ld_idx,   i);
            check_eq({name, ".load.data"},    ld_data,  (i == 0) ? o0 : o1);
            check_eq({name, ".load.cpu_rst"}, cpu_rst,  0);
            check_eq({name, ".load.cpu_en"},  cpu_en,   0);
        end
        for (int k = 1; k <= exp_cyc; k++) begin
            tick();
            check_eq({name, ".run.cpu_en"},   cpu_en,   1);
            check_eq({name, ".run.cpu_rst"},  cpu_rst,  0);
            check_eq({name, ".run.ld_valid"}, ld_valid, 0);
            check_eq({name, ".run.cycles"},   cycles,   k);
            check_eq({name, ".run.done"},     done,     0);
            pc = (k == match_k) ? halt : miss;
        end
        tick();
        start = chain;
        pc    = miss;
        check_eq({name, ".fin.done"},    done,    1);
        check_eq({name, ".fin.cpu_en"},  cpu_en,  0);
        check_eq({name, ".fin.busy"},    busy,    1);
        check_eq({name, ".fin.timeout"}, timeout, exp_to);
        check_eq({name, ".fin.cycles"},  cycles,  exp_cyc);
        tick();
        start = 1'b0;
        check_eq({name, ".idle.busy"},    busy,    0);
        check_eq({name, ".idle.done"},    done,    0);
        check_eq({name, ".idle.cpu_rst"}, cpu_rst, 0);
        check_eq({name, ".idle.timeout"}, timeout, exp_to);
        check_eq({name, ".idle.cycles"},  cycles,  exp_cyc);
        $display("run %s halt=%0d max=%0d -> cycles=%0d timeout=%0d", name, halt, maxc, cycles, timeout);
    endtask

    initial begin
        logic done_seen;
        logic crst_seen;
        rst        = 1'b1;
        start      = 1'b1;
        op_data    = '0;
        halt_addr  = '0;
        max_cycles = '0;
        pc         = '0;
        tick();
        tick();
        check_reset_vals("reset");
        $display("reset with start held -> busy=%0d cycles=%0d", busy, cycles);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check_eq("idle.busy", busy, 0);

        do_run("halt7", 32'd4123481, 32'd9402102, 8'd9, 8'd0, 7, 7, 1'b0, 1'b1);
        do_run("budget5", 32'hDEADBEEF, 32'h12345678, 8'd20, 8'd5, 0, 5, 1'b1, 1'b0);
        do_run("tie5", 32'd1, 32'd2, 8'd33, 8'd5, 5, 5, 1'b0, 1'b0);
        do_run("halt1", 32'hA5A5A5A5, 32'h5A5A5A5A, 8'd0, 8'd5, 1, 1, 1'b0, 1'b0);

        // Reset in the third RUN cycle.
        op_data    = {32'd77, 32'd66};
        halt_addr  = 8'd50;
        max_cycles = 8'd0;
        pc         = 8'd0;
        start      = 1'b1;
        for (int n = 0; n < 7; n++) tick();
        check_eq("midrun.cycles", cycles, 3);
        check_eq("midrun.cpu_en", cpu_en, 1);
        rst = 1'b1;
        tick();
        check_reset_vals("midrun_rst");
        $display("reset in RUN cycle 3 -> busy=%0d cycles=%0d", busy, cycles);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check_eq("midrun.idle.busy", busy, 0);
        do_run("after_rst", 32'd1000, 32'd2000, 8'd3, 8'd0, 4, 4, 1'b0, 1'b0);

        // Reset during LOAD.
        op_data = {32'd5, 32'd4};
        start   = 1'b1;
        tick();
        tick();
        tick();
        check_eq("midload.ld_valid", ld_valid, 1);
        check_eq("midload.ld_data",  ld_data,  4);
        rst = 1'b1;
        tick();
        check_reset_vals("midload_rst");
        $display("reset in LOAD -> busy=%0d ld_valid=%0d", busy, ld_valid);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // Start held, unlimited budget, no halt: single run, counter saturates.
        op_data    = {32'd9, 32'd8};
        halt_addr  = 8'd9;
        max_cycles = 8'd0;
        pc         = 8'd0;
        start      = 1'b1;
        done_seen  = 1'b0;
        crst_seen  = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        for (int k = 1; k <= (1 << CNT_W) + 3; k++) begin
            tick();
            done_seen = done_seen | done;
            crst_seen = crst_seen | cpu_rst;
            if (k == 255) check_eq("sat.cycles255", cycles, 255);
        end
        check_eq("sat.cycles_end", cycles,    255);
        check_eq("sat.done_seen",  done_seen, 0);
        check_eq("sat.restart",    crst_seen, 0);
        check_eq("sat.cpu_en",     cpu_en,    1);
        check_eq("sat.busy",       busy,      1);
        $display("saturation run -> cycles=%0d busy=%0d", cycles, busy);
        rst   = 1'b1;
        start = 1'b0;
        tick();
        check_reset_vals("final_rst");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
